// File: rtl/rb_uart_tx_if.sv
// Ring buffer read-side bundle between the buffer and its UART drain stage.
// master = drain stage (drives mode), slave = ring buffer (drives isEmpty/RData).
interface rb_uart_tx_if #(
    parameter int REG_WIDTH = 8
);
    logic [1:0]           mode;
    logic                 isEmpty;
    logic [REG_WIDTH-1:0] RData;

    modport master (
        output mode,
        input  isEmpty,
        input  RData
    );

    modport slave (
        input  mode,
        output isEmpty,
        output RData
    );
endinterface

// File: rtl/rb_uart_tx.sv
// Ring buffer drain stage: pops one entry per frame and serialises it as UART 8N1/8N2.
// Optional even-parity bit between DATA and STOP when RB_UART_TX_PARITY_EN is defined.
module rb_uart_tx #(
    parameter int REG_WIDTH    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int RD_LAT       = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    rb_uart_tx_if.master rb,
    output logic         tx,
    output logic         busy,
    output logic         byte_done
);

    localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BMAX = (REG_WIDTH > STOP_BITS) ? REG_WIDTH : STOP_BITS;
    localparam int BW   = $clog2(BMAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
`ifdef RB_UART_TX_PARITY_EN
        ST_PARITY = 3'd6,
`endif
        ST_STOP   = 3'd5
    } state_t;

    state_t               state_r, state_s;
    logic [CW-1:0]        cyc_r, cyc_s;
    logic [BW-1:0]        bit_r, bit_s;
    logic [REG_WIDTH-1:0] shift_r, shift_s;
    logic                 tx_r, tx_s;
    logic                 byte_done_r, done_s;
    logic                 bit_end_s;

`ifdef RB_UART_TX_PARITY_EN
    logic parity_r, parity_s;

    function automatic logic even_parity(input logic [REG_WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    // Next-state, counter, shift and registered-output decode
    always_comb begin
        state_s   = state_r;
        cyc_s     = cyc_r;
        bit_s     = bit_r;
        shift_s   = shift_r;
        done_s    = 1'b0;
        tx_s      = 1'b1;
        bit_end_s = (cyc_r == CW'(CLKS_PER_BIT - 1));

        case (state_r)
            ST_IDLE: begin
                if (enable && !rb.isEmpty) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // With zero read latency the data is already on RData during the strobe
                if (RD_LAT == 0) begin
                    state_s = ST_START;
                    shift_s = rb.RData;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            ST_LATCH: begin
                state_s = ST_START;
                shift_s = rb.RData;
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_s = ST_DATA;
                    cyc_s   = '0;
                    bit_s   = '0;
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_s = shift_r >> 1;
                    cyc_s   = '0;
                    if (bit_r == BW'(REG_WIDTH - 1)) begin
`ifdef RB_UART_TX_PARITY_EN
                        state_s = ST_PARITY;
`else
                        state_s = ST_STOP;
`endif
                        bit_s = '0;
                    end else begin
                        bit_s = bit_r + BW'(1);
                    end
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
`ifdef RB_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_s = ST_STOP;
                    cyc_s   = '0;
                    bit_s   = '0;
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    cyc_s = '0;
                    if (bit_r == BW'(STOP_BITS - 1)) begin
                        state_s = ST_IDLE;
                        bit_s   = '0;
                        done_s  = 1'b1;
                    end else begin
                        bit_s = bit_r + BW'(1);
                    end
                end else begin
                    cyc_s = cyc_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cyc_s   = '0;
                bit_s   = '0;
            end
        endcase

`ifdef RB_UART_TX_PARITY_EN
        // Parity is taken from the word exactly as it is captured on entry to START
        if ((state_s == ST_START) && (state_r != ST_START)) begin
            parity_s = even_parity(shift_s);
        end else begin
            parity_s = parity_r;
        end
`endif

        case (state_s)
            ST_START:  tx_s = 1'b0;
            ST_DATA:   tx_s = shift_s[0];
`ifdef RB_UART_TX_PARITY_EN
            ST_PARITY: tx_s = parity_s;
`endif
            default:   tx_s = 1'b1;
        endcase
    end

    // State, counters, data and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cyc_r       <= '0;
            bit_r       <= '0;
            shift_r     <= '0;
            tx_r        <= 1'b1;
            byte_done_r <= 1'b0;
`ifdef RB_UART_TX_PARITY_EN
            parity_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cyc_r       <= cyc_s;
            bit_r       <= bit_s;
            shift_r     <= shift_s;
            tx_r        <= tx_s;
            byte_done_r <= done_s;
`ifdef RB_UART_TX_PARITY_EN
            parity_r    <= parity_s;
`endif
        end
    end

    assign rb.mode   = (state_r == ST_FETCH) ? 2'b01 : 2'b00;
    assign busy      = (state_r != ST_IDLE);
    assign tx        = tx_r;
    assign byte_done = byte_done_r;

endmodule

// File: tb/tb_rb_uart_tx.sv
// Scoreboard bench for rb_uart_tx: behavioural ring buffer feeds the DUT, a UART
// receiver monitor decodes tx frames and checks them against queued expected bytes.
module tb_rb_uart_tx;
    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int RDL = 1;
    localparam int SB  = 1;
`ifdef RB_UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
    localparam int NB  = 2 + W + SB;
`else
    localparam bit PAR = 1'b0;
    localparam int NB  = 1 + W + SB;
`endif

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic tx, busy, byte_done;

    rb_uart_tx_if #(.REG_WIDTH(W)) bif ();

    rb_uart_tx #(
        .REG_WIDTH(W), .CLKS_PER_BIT(CPB), .RD_LAT(RDL), .STOP_BITS(SB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .rb(bif),
        .tx(tx), .busy(busy), .byte_done(byte_done)
    );

    always #5 clk = ~clk;

    // Behavioural ring buffer: registered read data, one pop per strobe cycle
    logic [7:0] mem [256];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign bif.isEmpty = (wr_cnt == rd_cnt);
    always @(posedge clk) begin
        if (bif.mode == 2'b01 && wr_cnt != rd_cnt) begin
            bif.RData <= mem[rd_cnt % 256];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] expected_frame(input logic [7:0] b);
        logic [15:0] f;
        int idx;
        f = '0;
        for (int i = 0; i < W; i++) f[1 + i] = b[i];
        idx = 1 + W;
        if (PAR) begin
            f[idx] = ^b;
            idx++;
        end
        for (int s = 0; s < SB; s++) f[idx + s] = 1'b1;
        return f;
    endfunction

    task automatic push_byte(input logic [7:0] b);
        mem[wr_cnt % 256] = b;
        wr_cnt++;
        exp_q.push_back(b);
    endtask

    // Monitor state
    bit          in_frame = 1'b0;
    int          pos = 0;
    logic [15:0] got;
    int          starts_n = 0;
    int          frames_n = 0;
    int          bd_n = 0;
    int          strobes = 0;
    bit          bad_mode = 1'b0;
    logic        bd_prev = 1'b0;
    int          start_cyc[$];
    int          done_cyc[$];

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bif.mode == 2'b01) strobes++;
            if (bif.mode[1] !== 1'b0) bad_mode = 1'b1;
            if (byte_done === 1'b1) bd_n++;
            if (byte_done === 1'b1 && bd_prev !== 1'b1) done_cyc.push_back(cyc);
            bd_prev = byte_done;
            if (reset) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1'b1;
                    pos = 0;
                    got = '0;
                    got[0] = tx;
                    starts_n++;
                    start_cyc.push_back(cyc);
                end
            end else begin
                pos++;
                if ((pos % CPB) == (CPB / 2) && (pos / CPB) < NB) got[pos / CPB] = tx;
                if (pos == NB * CPB - 1) check("byte_done_early", byte_done, 1'b0);
                if (pos == NB * CPB) begin
                    check("byte_done_at_frame_end", byte_done, 1'b1);
                    frames_n++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", got, 16'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", got, expected_frame(e));
                    end
                    in_frame = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int i = 0; i < budget && starts_n < n; i++) @(negedge clk);
        check("wait_start", (starts_n >= n), 1'b1);
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && frames_n < n; i++) @(negedge clk);
        check("wait_frame_done", (frames_n >= n), 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, s0, d0, st0;
        fork
            monitor();
        join_none

        // Reset with data already in the buffer
        reset  = 1'b1;
        enable = 1'b0;
        push_byte(8'hA5);
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_mode", bif.mode, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_byte_done", byte_done, 1'b0);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("no_strobe_in_reset", strobes, 0);
        check("tx_high_in_reset", tx, 1'b1);
        enable = 1'b0;
        reset  = 1'b0;
        repeat (5) @(negedge clk);
        check("no_strobe_disabled", strobes, 0);

        // Single byte 0xA5: latency, one strobe, frame length
        enable = 1'b1;
        t0 = cyc;
        wait_starts(1, 20);
        check("start_latency", start_cyc[0] - t0, 3);
        wait_frames(1, 100);
        check("single_strobe", strobes, 1);
        check("frame_length", done_cyc[0] - start_cyc[0], NB * CPB);

        // Three queued bytes back to back
        @(negedge clk);
        s0 = starts_n; d0 = done_cyc.size(); st0 = strobes;
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        wait_frames(frames_n + 3, 3 * (NB * CPB + 10));
        repeat (2) @(negedge clk);
        check("three_strobes", strobes - st0, 3);
        check("gap_1_2", start_cyc[s0 + 1] - done_cyc[d0], 3);
        check("gap_2_3", start_cyc[s0 + 2] - done_cyc[d0 + 1], 3);
        check("buffer_empty", bif.isEmpty, 1'b1);

        // enable dropped mid-frame
        s0 = starts_n; d0 = frames_n; st0 = strobes;
        push_byte(8'h11); push_byte(8'h22);
        wait_starts(s0 + 1, 20);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_frames(d0 + 1, 100);
        repeat (60) @(negedge clk);
        check("no_second_strobe", strobes - st0, 1);
        check("no_second_start", starts_n, s0 + 1);
        check("tx_idle_disabled", tx, 1'b1);
        enable = 1'b1;
        wait_frames(d0 + 2, 100);
        check("second_strobe_after_enable", strobes - st0, 2);

        // Reset in the third data bit of 0x3C
        s0 = starts_n; st0 = strobes;
        push_byte(8'h3C);
        wait_starts(s0 + 1, 20);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_frame && pos >= 12) break;
        end
        #1 reset = 1'b1;
        #1;
        check("tx_high_async_reset", tx, 1'b1);
        check("busy_low_async_reset", busy, 1'b0);
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check("strobes_after_reset", strobes - st0, 1);
        check("no_start_after_reset", starts_n, s0 + 1);
        check("tx_high_after_reset", tx, 1'b1);

        // Parity-relevant bytes
        d0 = frames_n;
        push_byte(8'h07); push_byte(8'h03);
        wait_frames(d0 + 2, 2 * (NB * CPB + 10));

        // Randomized bursts and gaps
        d0 = frames_n;
        for (int k = 0; k < 10; k++) begin
            push_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 60)) @(negedge clk);
        end
        wait_frames(d0 + 10, 10 * (NB * CPB + 10));
        repeat (5) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        check("mode_legal", bad_mode, 1'b0);
        check("byte_done_one_cycle", bd_n, done_cyc.size());
        check("pulse_per_frame", done_cyc.size(), frames_n);
        check("reads_match_writes", rd_cnt, wr_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rb_uart_tx.md
Name: rb_uart_tx

Overview:
- Downstream drain stage for Ring_Buffer. Pops one entry at a time using the buffer's mode/isEmpty/RData interface and serialises it onto a UART TX line as 8N1/8N2.
- Sits directly after the ring buffer and is the sole driver of the buffer's read request. The write side stays with the upstream producer.

Parameters:
- REG_WIDTH, 8: data width; must match the ring buffer's REG_WIDTH.
- CLKS_PER_BIT, 16: clk cycles per UART bit; legal values >= 2.
- RD_LAT, 1: cycles from the read-strobe edge to valid RData; legal values 0 or 1.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  allows new fetches; a frame in progress always completes.
- isEmpty  input  1  ring buffer empty flag.
- RData  input  REG_WIDTH  ring buffer read data.
- mode  output  2  ring buffer command: 2'b01 = read, 2'b00 = idle. Never drives 2'b10 or 2'b11.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high whenever state != IDLE.
- byte_done  output  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset: asserting reset forces state=IDLE, tx=1, mode=2'b00, busy=0, byte_done=0, and clears the bit and cycle counters and the shift register immediately, without waiting for clk.
- Outputs are glitch-free:
  - tx and byte_done are registered.
  - mode and busy are decoded from the state register only.
- States: IDLE, FETCH, LATCH, START, DATA, PARITY (PARITY only with the optional feature), STOP.
- IDLE:
  - If enable=1 and isEmpty=0 at edge E, go to FETCH.
  - isEmpty is sampled only in IDLE.
- FETCH:
  - Lasts exactly one cycle with mode=2'b01; this yields exactly one pop per frame.
  - If RD_LAT=0: capture RData into the shift register at edge E+1 and go to START.
  - If RD_LAT=1: go to LATCH at E+1.
- LATCH (RD_LAT=1 only): mode=2'b00; capture RData at edge E+2 and go to START.
- tx timing:
  - tx goes low on the edge that enters START: E+1 when RD_LAT=0, E+2 when RD_LAT=1.
  - Each bit is held for exactly CLKS_PER_BIT cycles, counted by a cycle counter that runs 0..CLKS_PER_BIT-1.
- Bit sequence:
  - START: one bit, tx=0.
  - DATA: REG_WIDTH bits, LSB first; a bit index counts 0..REG_WIDTH-1 and the shift register shifts right once per bit.
  - STOP: STOP_BITS bits, tx=1.
- End of frame: on the edge that ends the final stop bit, byte_done=1 for one cycle and the state returns to IDLE.
  - The IDLE check happens on the next edge, so consecutive frames are separated by exactly one extra tx-high cycle (plus the FETCH/LATCH cycles, during which tx also stays high).
- Frame length, START through STOP: (1 + REG_WIDTH + STOP_BITS) * CLKS_PER_BIT cycles.
- enable deasserted mid-frame: the current frame completes normally, and no further FETCH is issued.
- isEmpty asserting during a frame has no effect on that frame.
- Reset mid-frame: tx returns high asynchronously and the captured byte is discarded. That entry has already been popped from the buffer and is lost; this is accepted behaviour.
- Counters never wrap within a frame: the bit index and cycle counter reset to 0 on every state change.

Optional Feature:
- Macro: RB_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting one bit time.
  - tx carries even parity, i.e. the XOR of all REG_WIDTH data bits.
  - Frame length becomes (2 + REG_WIDTH + STOP_BITS) * CLKS_PER_BIT.
- Undefined: the PARITY state, parity register and parity logic are absent, and the frame goes straight from DATA to STOP.

Test Plan (CLKS_PER_BIT=4, RD_LAT=1, STOP_BITS=1, REG_WIDTH=8, behavioural ring buffer model, parity macro undefined unless stated):
- Reset with the buffer holding data -> tx=1, mode=00, busy=0 and byte_done=0 before the first clk edge; no read is issued while reset is high.
- Single byte 0xA5, enable=1 -> exactly one mode=01 cycle; tx low 2 cycles after the edge where IDLE saw isEmpty=0; bit sequence 0,1,0,1,0,0,1,0,1 then 1, each bit 4 cycles wide; byte_done pulses once, 40 cycles after tx fell.
- Buffer holding 0x01, 0x02, 0x03 -> three frames with exactly 3 tx-high cycles between stop-bit end and the next start bit; exactly 3 read strobes; the buffer reports isEmpty=1 afterwards.
- enable dropped in the middle of frame 1 of two queued bytes (0x11, 0x22) -> frame 0x11 completes; no second strobe; tx stays high. Re-assert enable -> 0x22 is sent.
- Reset asserted in the 3rd data bit of 0x3C -> tx=1 immediately; after release, with the buffer empty, there are no strobes and tx stays high.
- With RB_UART_TX_PARITY_EN: send 0x07 -> parity bit 1 between bit 7 and stop, frame 44 cycles; send 0x03 -> parity bit 0.
